// File: rtl/serve_controller.sv
// Purpose : sequences each Pong serve (idle/collect/wait/launch/play) and turns
//           four random bits into the ball's serve direction and vertical speed.
// Latency : start edge at clk N -> serve_valid at N+6+DELAY-dependent WAIT clks.
// Flow    : no backpressure; serve_valid is a one-clk pulse the ball logic must take.
// Ports   : clk/rst (async active-low); rand_bit, frame_tick, start_btn,
//           point_scored, scorer in; serve_valid, dir_x, dir_y, speed_y,
//           ball_active, countdown out (all registered).
module serve_controller #(
  parameter int unsigned DELAY_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rand_bit,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       point_scored,
  input  logic       scorer,
  output logic       serve_valid,
  output logic       dir_x,
  output logic       dir_y,
  output logic [1:0] speed_y,
  output logic       ball_active,
  output logic [7:0] countdown
);

  typedef enum logic [2:0] {IDLE, COLLECT, WAIT, LAUNCH, PLAY} state_t;

  localparam logic [7:0] DELAY_LOAD = 8'(DELAY_FRAMES);

  state_t     state_q, state_d;
  logic       btn_prev_q, btn_prev_d;
  logic [3:0] bits_q, bits_d;
  logic [1:0] bit_cnt_q, bit_cnt_d;
  logic       first_serve_q, first_serve_d;
  logic       last_scorer_q, last_scorer_d;
  logic       serve_valid_q, serve_valid_d;
  logic       dir_x_q, dir_x_d;
  logic       dir_y_q, dir_y_d;
  logic [1:0] speed_y_q, speed_y_d;
  logic       ball_active_q, ball_active_d;
  logic [7:0] countdown_q, countdown_d;

  always_comb begin
    state_d       = state_q;
    btn_prev_d    = start_btn;
    bits_d        = bits_q;
    bit_cnt_d     = bit_cnt_q;
    first_serve_d = first_serve_q;
    last_scorer_d = last_scorer_q;
    serve_valid_d = 1'b0;
    dir_x_d       = dir_x_q;
    dir_y_d       = dir_y_q;
    speed_y_d     = speed_y_q;
    ball_active_d = ball_active_q;
    countdown_d   = countdown_q;

    case (state_q)
      IDLE: begin
        if (start_btn && !btn_prev_q) begin
          state_d       = COLLECT;
          first_serve_d = 1'b1;
          bit_cnt_d     = 2'd0;
        end
      end
      COLLECT: begin
        // b0 lands in bit 0, b3 in bit 3
        bits_d[bit_cnt_q] = rand_bit;
        bit_cnt_d         = bit_cnt_q + 2'd1;
        if (bit_cnt_q == 2'd3) begin
          state_d     = WAIT;
          countdown_d = DELAY_LOAD;
        end
      end
      WAIT: begin
        // Zero check takes priority so a tick at zero never underflows
        if (countdown_q == 8'd0) begin
          state_d = LAUNCH;
        end else if (frame_tick) begin
          countdown_d = countdown_q - 8'd1;
        end
      end
      LAUNCH: begin
        serve_valid_d = 1'b1;
        dir_y_d       = bits_q[0];
        // A zero vertical speed would trap the ball on one row
        speed_y_d     = ({bits_q[1], bits_q[2]} == 2'b00) ? 2'b01 : {bits_q[1], bits_q[2]};
        // Later serves go toward the player who just lost the point
        dir_x_d       = first_serve_q ? bits_q[3] : ~last_scorer_q;
        first_serve_d = 1'b0;
        state_d       = PLAY;
      end
      PLAY: begin
        ball_active_d = 1'b1;
        if (point_scored) begin
          last_scorer_d = scorer;
          ball_active_d = 1'b0;
          bit_cnt_d     = 2'd0;
          state_d       = COLLECT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      // Starts high so a button held through reset is not seen as an edge
      btn_prev_q    <= 1'b1;
      bits_q        <= 4'd0;
      bit_cnt_q     <= 2'd0;
      first_serve_q <= 1'b1;
      last_scorer_q <= 1'b0;
      serve_valid_q <= 1'b0;
      dir_x_q       <= 1'b0;
      dir_y_q       <= 1'b0;
      speed_y_q     <= 2'b01;
      ball_active_q <= 1'b0;
      countdown_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      btn_prev_q    <= btn_prev_d;
      bits_q        <= bits_d;
      bit_cnt_q     <= bit_cnt_d;
      first_serve_q <= first_serve_d;
      last_scorer_q <= last_scorer_d;
      serve_valid_q <= serve_valid_d;
      dir_x_q       <= dir_x_d;
      dir_y_q       <= dir_y_d;
      speed_y_q     <= speed_y_d;
      ball_active_q <= ball_active_d;
      countdown_q   <= countdown_d;
    end
  end

  assign serve_valid = serve_valid_q;
  assign dir_x       = dir_x_q;
  assign dir_y       = dir_y_q;
  assign speed_y     = speed_y_q;
  assign ball_active = ball_active_q;
  assign countdown   = countdown_q;

endmodule

// File: tb/tb_serve_controller.sv
// Purpose : self-checking bench for serve_controller, two instances (DELAY 0 and 3)
//           sharing one stimulus stream, checked against a rule-level model.
// Latency : n/a.
// Flow    : n/a.
module tb_serve_controller;

  logic clk = 1'b0;
  logic rst, rand_bit, frame_tick, start_btn, point_scored, scorer;
  logic z_sv, z_dx, z_dy, z_ba;
  logic [1:0] z_sp;
  logic [7:0] z_cd;
  logic t_sv, t_dx, t_dy, t_ba;
  logic [1:0] t_sp;
  logic [7:0] t_cd;

  serve_controller #(.DELAY_FRAMES(0)) dut_z (
    .clk(clk), .rst(rst), .rand_bit(rand_bit), .frame_tick(frame_tick),
    .start_btn(start_btn), .point_scored(point_scored), .scorer(scorer),
    .serve_valid(z_sv), .dir_x(z_dx), .dir_y(z_dy), .speed_y(z_sp),
    .ball_active(z_ba), .countdown(z_cd));

  serve_controller #(.DELAY_FRAMES(3)) dut_t (
    .clk(clk), .rst(rst), .rand_bit(rand_bit), .frame_tick(frame_tick),
    .start_btn(start_btn), .point_scored(point_scored), .scorer(scorer),
    .serve_valid(t_sv), .dir_x(t_dx), .dir_y(t_dy), .speed_y(t_sp),
    .ball_active(t_ba), .countdown(t_cd));

  always #5 clk = ~clk;

  // Edge k samples the inputs recorded at index k
  int cyc = 0;
  bit rb_hist [8192];
  bit tk_hist [8192];
  int obs_cd  [8192];
  always @(posedge clk) begin
    rb_hist[cyc] <= rand_bit;
    tk_hist[cyc] <= frame_tick;
    cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int tick_period = 0;
  bit extra_tick  = 1'b0;
  bit m_first = 1'b1;
  bit m_last  = 1'b0;

  task step();
    @(posedge clk);
    #1;
    rand_bit     = 1'($urandom_range(0, 1));
    frame_tick   = ((tick_period != 0) && ((cyc % tick_period) == 0)) || extra_tick;
    point_scored = 1'b0;
  endtask

  task apply_reset();
    rst = 1'b0;
    frame_tick = 1'b0;
    point_scored = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    m_first = 1'b1;
    m_last  = 1'b0;
  endtask

  task press(output int n);
    start_btn = 1'b0;
    step();
    start_btn = 1'b1;
    n = cyc;
  endtask

  task wait_serve(input bit which, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      @(negedge clk);
      obs_cd[cyc-1] = int'(t_cd);
      if (which ? t_sv : z_sv) begin
        at = cyc - 1;
        break;
      end
    end
  endtask

  // Serve prediction from the game rules: bits from the four clks after the
  // trigger, launch two clks after the d-th counted frame tick
  task automatic model_serve(input int n, input int d, output int exp_at,
                             output logic ex, output logic ey, output logic [1:0] es);
    int t, cnt;
    logic [1:0] raw;
    t = n + 4;
    cnt = 0;
    if (d > 0) begin
      t = -100;
      for (int e = n + 5; e < cyc; e++) begin
        if (tk_hist[e]) begin
          cnt++;
          if (cnt == d) begin
            t = e;
            break;
          end
        end
      end
    end
    exp_at = t + 2;
    ey  = rb_hist[n+1];
    raw = {rb_hist[n+2], rb_hist[n+3]};
    es  = (raw == 2'b00) ? 2'b01 : raw;
    ex  = m_first ? rb_hist[n+4] : ~m_last;
  endtask

  function automatic int exp_cd(int n, int d, int e);
    int ticks;
    if (e < n + 4) return 0;
    ticks = 0;
    for (int k = n + 5; k <= e; k++) ticks += tk_hist[k] ? 1 : 0;
    return (d > ticks) ? d - ticks : 0;
  endfunction

  task test_reset();
    bit seen;
    start_btn = 1'b1;
    tick_period = 4;
    apply_reset();
    // Sample the async reset values while still inside a fresh reset
    rst = 1'b0;
    #2;
    n_checks++; if (t_sv !== 1'b0) begin n_fail++; $display("FAIL reset_sv got %b want 0", t_sv); end
    n_checks++; if (t_ba !== 1'b0) begin n_fail++; $display("FAIL reset_ba got %b want 0", t_ba); end
    n_checks++; if ({t_dx, t_dy} !== 2'b00) begin n_fail++; $display("FAIL reset_dir got %b want 00", {t_dx, t_dy}); end
    n_checks++; if (t_sp !== 2'b01) begin n_fail++; $display("FAIL reset_speed got %b want 01", t_sp); end
    n_checks++; if (t_cd !== 8'd0) begin n_fail++; $display("FAIL reset_cd got %0d want 0", t_cd); end
    @(posedge clk); #1 rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      @(negedge clk);
      if (z_sv || t_sv || z_ba || t_ba || (t_cd != 8'd0)) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL reset_hold activity got %b want 0", seen); end
  endtask

  task test_first_serve();
    int n, at, ea;
    logic ex, ey;
    logic [1:0] es;
    tick_period = 0;
    apply_reset();
    press(n);
    step(); rand_bit = 1'b1;
    step(); rand_bit = 1'b0;
    step(); rand_bit = 1'b1;
    step(); rand_bit = 1'b1;
    wait_serve(1'b0, 20, at);
    model_serve(n, 0, ea, ex, ey, es);
    n_checks++; if (at !== n + 6) begin n_fail++; $display("FAIL first_latency got %0d want %0d", at - n, 6); end
    n_checks++; if (at !== ea) begin n_fail++; $display("FAIL first_model_at got %0d want %0d", at, ea); end
    n_checks++; if ({z_dx, z_dy, z_sp} !== {ex, ey, es}) begin n_fail++; $display("FAIL first_params got %b want %b", {z_dx, z_dy, z_sp}, {ex, ey, es}); end
    n_checks++; if (z_ba !== 1'b0) begin n_fail++; $display("FAIL first_ba_early got %b want 0", z_ba); end
    step(); @(negedge clk);
    n_checks++; if (z_ba !== 1'b1) begin n_fail++; $display("FAIL first_ba got %b want 1", z_ba); end
    n_checks++; if (z_sv !== 1'b0) begin n_fail++; $display("FAIL first_sv_pulse got %b want 0", z_sv); end
  endtask

  task test_zero_speed();
    int n, at, ea;
    logic ex, ey;
    logic [1:0] es;
    tick_period = 0;
    apply_reset();
    press(n);
    repeat (4) begin step(); rand_bit = 1'b0; end
    wait_serve(1'b0, 20, at);
    model_serve(n, 0, ea, ex, ey, es);
    n_checks++; if (at !== ea) begin n_fail++; $display("FAIL zero_at got %0d want %0d", at, ea); end
    n_checks++; if ({z_dx, z_dy, z_sp} !== {ex, ey, es}) begin n_fail++; $display("FAIL zero_params got %b want %b", {z_dx, z_dy, z_sp}, {ex, ey, es}); end
  endtask

  task test_countdown();
    int n, at, ea, bad;
    logic ex, ey;
    logic [1:0] es;
    tick_period = 10;
    apply_reset();
    press(n);
    extra_tick = 1'b1;  // ticks during COLLECT and at WAIT entry must be ignored
    repeat (4) begin step(); @(negedge clk); obs_cd[cyc-1] = int'(t_cd); end
    extra_tick = 1'b0;
    wait_serve(1'b1, 200, at);
    model_serve(n, 3, ea, ex, ey, es);
    n_checks++; if (at !== ea) begin n_fail++; $display("FAIL cd_at got %0d want %0d", at, ea); end
    n_checks++; if ({t_dx, t_dy, t_sp} !== {ex, ey, es}) begin n_fail++; $display("FAIL cd_params got %b want %b", {t_dx, t_dy, t_sp}, {ex, ey, es}); end
    bad = 0;
    if (at > n) for (int e = n + 1; e <= at; e++) begin
      n_checks++;
      if (obs_cd[e] !== exp_cd(n, 3, e)) begin
        n_fail++;
        if (bad++ < 4) $display("FAIL cd_value edge %0d got %0d want %0d", e - n, obs_cd[e], exp_cd(n, 3, e));
      end
    end
  endtask

  task test_reserve();
    int n, m, at, ea;
    logic ex, ey;
    logic [1:0] es;
    bit seen;
    tick_period = 3;
    apply_reset();
    press(n);
    wait_serve(1'b1, 200, at);
    model_serve(n, 3, ea, ex, ey, es);
    n_checks++; if ({at, t_dx, t_dy, t_sp} !== {ea, ex, ey, es}) begin n_fail++; $display("FAIL rs_first got at=%0d %b want at=%0d %b", at, {t_dx, t_dy, t_sp}, ea, {ex, ey, es}); end
    m_first = 1'b0;
    // Button edges in PLAY must not restart anything
    step(); start_btn = 1'b0;
    step(); start_btn = 1'b1;
    seen = 1'b0;
    repeat (6) begin step(); @(negedge clk); if (t_sv || !t_ba) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL rs_btn_in_play disturbed=%b want 0", seen); end
    for (int k = 0; k < 2; k++) begin
      step();
      point_scored = 1'b1;
      scorer = (k == 0) ? 1'b1 : 1'b0;
      m = cyc;
      step();
      @(negedge clk);
      n_checks++; if (t_ba !== 1'b0) begin n_fail++; $display("FAIL rs_ba_drop got %b want 0", t_ba); end
      m_last = scorer;
      wait_serve(1'b1, 200, at);
      model_serve(m, 3, ea, ex, ey, es);
      n_checks++; if (at !== ea) begin n_fail++; $display("FAIL rs_at got %0d want %0d", at, ea); end
      n_checks++; if (t_dx !== ex) begin n_fail++; $display("FAIL rs_dir_x got %b want %b", t_dx, ex); end
      n_checks++; if ({t_dy, t_sp} !== {ey, es}) begin n_fail++; $display("FAIL rs_dy_sp got %b want %b", {t_dy, t_sp}, {ey, es}); end
      step(); @(negedge clk);
      n_checks++; if (t_ba !== 1'b1) begin n_fail++; $display("FAIL rs_ba_rise got %b want 1", t_ba); end
    end
  endtask

  task test_spurious();
    int n, at, ea;
    logic ex, ey;
    logic [1:0] es;
    bit seen;
    tick_period = 10;
    apply_reset();
    press(n);
    repeat (6) step();
    point_scored = 1'b1;  // lands mid-WAIT
    scorer = 1'b1;
    wait_serve(1'b1, 200, at);
    model_serve(n, 3, ea, ex, ey, es);
    n_checks++; if (at !== ea) begin n_fail++; $display("FAIL sp_at got %0d want %0d", at, ea); end
    n_checks++; if (t_dx !== ex) begin n_fail++; $display("FAIL sp_dir_x got %b want %b", t_dx, ex); end
    // Reset pulse while in WAIT
    apply_reset();
    press(n);
    repeat (8) step();
    @(negedge clk);
    n_checks++; if (int'(t_cd) !== exp_cd(n, 3, cyc - 1)) begin n_fail++; $display("FAIL sp_mid_cd got %0d want %0d", t_cd, exp_cd(n, 3, cyc - 1)); end
    rst = 1'b0;
    #2;
    n_checks++; if ({t_cd, t_ba, t_sv} !== 10'd0) begin n_fail++; $display("FAIL sp_async_rst got cd=%0d ba=%b sv=%b want 0", t_cd, t_ba, t_sv); end
    @(posedge clk); #1 rst = 1'b1;
    m_first = 1'b1;
    m_last  = 1'b0;
    seen = 1'b0;
    repeat (60) begin step(); @(negedge clk); if (t_sv || z_sv || (t_cd != 8'd0)) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL sp_no_serve_after_rst got %b want 0", seen); end
    press(n);
    wait_serve(1'b1, 200, at);
    model_serve(n, 3, ea, ex, ey, es);
    n_checks++; if ({at, t_dx, t_dy, t_sp} !== {ea, ex, ey, es}) begin n_fail++; $display("FAIL sp_new_serve got at=%0d %b want at=%0d %b", at, {t_dx, t_dy, t_sp}, ea, {ex, ey, es}); end
  endtask

  initial begin
    rst = 1'b0;
    rand_bit = 1'b0;
    frame_tick = 1'b0;
    start_btn = 1'b0;
    point_scored = 1'b0;
    scorer = 1'b0;
    test_reset();
    test_first_serve();
    test_zero_speed();
    test_countdown();
    test_reserve();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
